branch_resolve: RTL and testbench
=================================

# branch_resolve

Execute-stage branch resolution unit: the consuming end of the fetch-side next-PC prediction path. It owns the 2-bit pattern history table (PHT) whose direction bit feeds fetch next-PC selection, and it compares each resolved instruction's actual next PC against the next PC fetch predicted. On a mismatch it issues a registered redirect and a timed pipeline flush, trains the PHT on every resolved branch, and issues target-buffer refill writes for taken control transfers that fetch got wrong.

## Interface
- PC_WIDTH, 32, PC width in bits
- PHT_IDX_W, 3, PHT index width; index = PC[PHT_IDX_W+1:2], the same slice the target buffer uses
- FLUSH_CYCLES, 2, cycles flush_o is held after a mispredict (≥1)

- clk_i  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- F_PC_i  in  PC_WIDTH  current fetch PC (PHT read address)
- F_train_predict_o  out  1  predicted taken: MSB of PHT[F_PC_i index], combinational
- E_valid_i  in  1  execute-stage instruction valid
- E_PC_i  in  PC_WIDTH  PC of the resolving instruction
- E_op_branch_i  in  1  conditional branch
- E_op_jal_i  in  1  unconditional jump
- E_taken_i  in  1  branch outcome (ignored unless E_op_branch_i)
- E_target_i  in  PC_WIDTH  resolved branch/jump target
- E_pred_nPC_i  in  PC_WIDTH  next PC fetch actually used for this instruction
- redirect_o  out  1  one-cycle redirect pulse
- redirect_PC_o  out  PC_WIDTH  correct next PC, valid with redirect_o
- flush_o  out  1  kill younger in-flight instructions
- btb_wr_o  out  1  target-buffer write pulse
- btb_wr_PC_o  out  PC_WIDTH  tag/index PC for the write
- btb_wr_target_o  out  PC_WIDTH  target to store

## Operation
- Actual taken: taken = E_op_jal_i | (E_op_branch_i & E_taken_i).
- Actual next PC: actual_nPC = taken ? E_target_i : E_PC_i + 4, computed modulo 2^PC_WIDTH.
- Non-control instructions resolve with actual_nPC = E_PC_i + 4.
- Accepted: E_valid_i & (state == IDLE).
- Mispredict: accepted & (actual_nPC != E_pred_nPC_i).
- FSM states:
  - IDLE: on mispredict, load flush counter with FLUSH_CYCLES and go to FLUSH.
  - FLUSH: decrement the counter each cycle; return to IDLE when the count reaches 1.
  - In FLUSH, E_valid_i is ignored entirely (wrong-path): no PHT update, no BTB write, no new redirect.
- PHT: 2^PHT_IDX_W 2-bit saturating counters.
  - Each accepted E_op_branch_i updates PHT[E_PC_i index]: increment if E_taken_i, else decrement; saturate at 3 and 0.
  - E_op_jal_i does not train the PHT.
- BTB refill: an accepted mispredict with taken=1 issues a write of {E_PC_i, E_target_i}.
  - A mispredict with taken=0 issues no write.
- Simultaneous E_op_branch_i and E_op_jal_i is treated as jal (taken=1, no PHT training).

## Timing
- Reset (rst low, asynchronous): state=IDLE, counter=0, redirect_o=0, redirect_PC_o=0, flush_o=0, btb_wr_o=0, btb_wr_PC_o=0, btb_wr_target_o=0, all PHT entries=2'b01 (weakly not-taken).
- Reset asserted mid-flush aborts the flush immediately; all outputs return to reset values.
- Mispredict accepted in cycle T:
  - redirect_o=1 and redirect_PC_o=actual_nPC in cycle T+1 only.
  - flush_o=1 in cycles T+1 through T+FLUSH_CYCLES.
  - btb_wr_* valid in T+1, one cycle.
  - First accepted instruction can appear in cycle T+FLUSH_CYCLES+1.
- PHT write takes effect at the rising edge ending cycle T; a read of the same index in T+1 sees the new value.
- F_train_predict_o has zero latency from F_PC_i.
- All outputs except F_train_predict_o are registered.

## Configuration
- BRU_PHT_BYPASS_EN defined:
  - If an accepted branch in cycle T updates the index that F_PC_i selects in the same cycle, F_train_predict_o shows the MSB of the updated counter in cycle T.
- BRU_PHT_BYPASS_EN undefined:
  - F_train_predict_o shows the stored (pre-update) value in cycle T; no forwarding path.

## Test plan
- Reset and initial read: after reset, F_PC_i=0x0000_0010 -> F_train_predict_o=0; all registered outputs 0.
- Correct prediction: non-branch at PC 0x100 with E_pred_nPC_i=0x104 -> no redirect, no flush, no BTB write.
- Taken branch mispredict, FLUSH_CYCLES=2: branch at 0x200, taken, target 0x180, E_pred_nPC_i=0x204, in cycle T -> redirect_o pulse and redirect_PC_o=0x180 in T+1; flush_o high in T+1..T+2; btb_wr 0x200→0x180 in T+1; PHT[0] becomes 2.
- Wrong-path suppression: during the T+1..T+2 flush, drive a valid taken branch at 0x208 -> PHT[2] unchanged, no second redirect, no BTB write.
- Not-taken mispredict: branch at 0x300, not taken, E_pred_nPC_i=0x340 -> redirect_PC_o=0x304; btb_wr_o stays 0; PHT[0] decrements.
- Saturation and bypass: four taken branches at 0x20 -> PHT[0] saturates at 3; with F_PC_i=0x20 during the 01→10 update, F_train_predict_o=1 in that cycle only when BRU_PHT_BYPASS_EN is defined, else 1 in the following cycle.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Branch resolution bus: groups the fetch-side PHT read port, the execute-stage
// resolve inputs and the redirect/flush/target-buffer refill outputs.
//   master : driven by fetch/execute (PC lookup, resolved instruction info)
//   slave  : the branch_resolve unit (prediction, redirect, flush, refill)
interface branch_resolve_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] F_PC_i;
  logic                F_train_predict_o;
  logic                E_valid_i;
  logic [PC_WIDTH-1:0] E_PC_i;
  logic                E_op_branch_i;
  logic                E_op_jal_i;
  logic                E_taken_i;
  logic [PC_WIDTH-1:0] E_target_i;
  logic [PC_WIDTH-1:0] E_pred_nPC_i;
  logic                redirect_o;
  logic [PC_WIDTH-1:0] redirect_PC_o;
  logic                flush_o;
  logic                btb_wr_o;
  logic [PC_WIDTH-1:0] btb_wr_PC_o;
  logic [PC_WIDTH-1:0] btb_wr_target_o;

  modport master (
    output F_PC_i, E_valid_i, E_PC_i, E_op_branch_i, E_op_jal_i, E_taken_i,
           E_target_i, E_pred_nPC_i,
    input  F_train_predict_o, redirect_o, redirect_PC_o, flush_o, btb_wr_o,
           btb_wr_PC_o, btb_wr_target_o
  );

  modport slave (
    input  F_PC_i, E_valid_i, E_PC_i, E_op_branch_i, E_op_jal_i, E_taken_i,
           E_target_i, E_pred_nPC_i,
    output F_train_predict_o, redirect_o, redirect_PC_o, flush_o, btb_wr_o,
           btb_wr_PC_o, btb_wr_target_o
  );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution unit.
// Owns the 2-bit pattern history table feeding fetch's taken prediction,
// compares each resolved instruction's real next PC with the one fetch used,
// and on a mismatch raises a registered redirect, a FLUSH_CYCLES-long flush
// and (for taken transfers) a target-buffer refill write.
// Ports:
//   clk_i  - clock, rising edge
//   rst    - asynchronous active-low reset
//   bus    - branch_resolve_if.slave (fetch lookup, resolve inputs, outputs)
// Optional feature: define BRU_PHT_BYPASS_EN to forward a same-cycle PHT
// update to F_train_predict_o.
module branch_resolve #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned PHT_IDX_W    = 3,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic            clk_i,
  input logic            rst,
  branch_resolve_if.slave bus
);

  localparam int unsigned PhtDepth = 1 << PHT_IDX_W;
  localparam int unsigned CntW     = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          pht_q [PhtDepth];

  logic                redirect_q;
  logic [PC_WIDTH-1:0] redirect_pc_q;
  logic                flush_q;
  logic                btb_wr_q;
  logic [PC_WIDTH-1:0] btb_wr_pc_q;
  logic [PC_WIDTH-1:0] btb_wr_target_q;

  logic                taken;
  logic [PC_WIDTH-1:0] actual_npc;
  logic                accepted;
  logic                mispredict;
  logic                pht_upd;
  logic [PHT_IDX_W-1:0] e_idx;
  logic [PHT_IDX_W-1:0] f_idx;
  logic [1:0]          pht_old;
  logic [1:0]          pht_new;
  logic                unused_fpc;

  // jal wins over a simultaneously flagged branch.
  assign taken      = bus.E_op_jal_i | (bus.E_op_branch_i & bus.E_taken_i);
  assign actual_npc = taken ? bus.E_target_i : bus.E_PC_i + PC_WIDTH'(4);
  assign accepted   = bus.E_valid_i & (state_q == StIdle);
  assign mispredict = accepted & (actual_npc != bus.E_pred_nPC_i);
  assign pht_upd    = accepted & bus.E_op_branch_i & ~bus.E_op_jal_i;

  assign e_idx = bus.E_PC_i[PHT_IDX_W+1:2];
  assign f_idx = bus.F_PC_i[PHT_IDX_W+1:2];
  assign unused_fpc = ^{bus.F_PC_i[PC_WIDTH-1:PHT_IDX_W+2], bus.F_PC_i[1:0]};

  always_comb begin
    pht_old = pht_q[e_idx];
    pht_new = pht_old;
    if (bus.E_taken_i) begin
      if (pht_old != 2'b11) pht_new = pht_old + 2'b01;
    end else begin
      if (pht_old != 2'b00) pht_new = pht_old - 2'b01;
    end
  end

`ifdef BRU_PHT_BYPASS_EN
  assign bus.F_train_predict_o = (pht_upd && (e_idx == f_idx)) ? pht_new[1] : pht_q[f_idx][1];
`else
  assign bus.F_train_predict_o = pht_q[f_idx][1];
`endif

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(PhtDepth); i++) pht_q[i] <= 2'b01;
    end else if (pht_upd) begin
      pht_q[e_idx] <= pht_new;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mispredict) begin
          state_d = StFlush;
          cnt_d   = CntW'(FLUSH_CYCLES);
        end
      end
      StFlush: begin
        // Count 1 marks the last flush cycle.
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      redirect_q      <= 1'b0;
      redirect_pc_q   <= '0;
      flush_q         <= 1'b0;
      btb_wr_q        <= 1'b0;
      btb_wr_pc_q     <= '0;
      btb_wr_target_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redirect_q <= mispredict;
      flush_q    <= (state_d == StFlush);
      btb_wr_q   <= mispredict & taken;
      if (mispredict) redirect_pc_q <= actual_npc;
      if (mispredict & taken) begin
        btb_wr_pc_q     <= bus.E_PC_i;
        btb_wr_target_q <= bus.E_target_i;
      end
    end
  end

  assign bus.redirect_o      = redirect_q;
  assign bus.redirect_PC_o   = redirect_pc_q;
  assign bus.flush_o         = flush_q;
  assign bus.btb_wr_o        = btb_wr_q;
  assign bus.btb_wr_PC_o     = btb_wr_pc_q;
  assign bus.btb_wr_target_o = btb_wr_target_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  localparam int FlushCycles = 2;
`ifdef BRU_PHT_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst   = 1'b0;
  always #5 clk_i = ~clk_i;

  branch_resolve_if #(.PC_WIDTH(32)) bus ();

  branch_resolve #(
    .PC_WIDTH    (32),
    .PHT_IDX_W   (3),
    .FLUSH_CYCLES(FlushCycles)
  ) dut (
    .clk_i(clk_i),
    .rst  (rst),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: counters as plain integers, flush as cycles remaining.
  int pht [8];
  int flush_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) pht[i] = 1;
    flush_left = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_redirect"}, {31'b0, bus.redirect_o}, 32'd0);
    check({tag, "_redirect_pc"}, bus.redirect_PC_o, 32'd0);
    check({tag, "_flush"}, {31'b0, bus.flush_o}, 32'd0);
    check({tag, "_btb_wr"}, {31'b0, bus.btb_wr_o}, 32'd0);
    check({tag, "_btb_pc"}, bus.btb_wr_PC_o, 32'd0);
    check({tag, "_btb_tgt"}, bus.btb_wr_target_o, 32'd0);
  endtask

  // Called at posedge+1; drives one cycle, checks prediction mid-cycle and
  // the registered outputs just after the closing edge.
  task automatic do_cycle(input bit v, input logic [31:0] pc, input bit br, input bit jal,
                          input bit tk, input logic [31:0] tgt, input logic [31:0] pred,
                          input logic [31:0] fpc);
    logic [31:0] anpc;
    bit taken, acc, mis, upd;
    int eidx, fidx, newc, pexp;
    bus.E_valid_i     = v;
    bus.E_PC_i        = pc;
    bus.E_op_branch_i = br;
    bus.E_op_jal_i    = jal;
    bus.E_taken_i     = tk;
    bus.E_target_i    = tgt;
    bus.E_pred_nPC_i  = pred;
    bus.F_PC_i        = fpc;
    taken = jal || (br && tk);
    anpc  = taken ? tgt : pc + 32'd4;
    acc   = v && (flush_left == 0);
    mis   = acc && (anpc != pred);
    upd   = acc && br && !jal;
    eidx  = int'((pc >> 2) % 8);
    fidx  = int'((fpc >> 2) % 8);
    newc  = pht[eidx];
    if (upd) newc = tk ? ((newc < 3) ? newc + 1 : 3) : ((newc > 0) ? newc - 1 : 0);
    pexp = pht[fidx];
    if (Bypass && upd && eidx == fidx) pexp = newc;
    #2;
    check("predict", {31'b0, bus.F_train_predict_o}, (pexp >= 2) ? 32'd1 : 32'd0);
    if (upd) pht[eidx] = newc;
    flush_left = mis ? FlushCycles : ((flush_left > 0) ? flush_left - 1 : 0);
    @(posedge clk_i);
    #1;
    check("redirect", {31'b0, bus.redirect_o}, {31'b0, mis});
    check("flush", {31'b0, bus.flush_o}, (flush_left > 0) ? 32'd1 : 32'd0);
    check("btb_wr", {31'b0, bus.btb_wr_o}, {31'b0, mis && taken});
    if (mis) check("redirect_pc", bus.redirect_PC_o, anpc);
    if (mis && taken) begin
      check("btb_pc", bus.btb_wr_PC_o, pc);
      check("btb_tgt", bus.btb_wr_target_o, tgt);
    end
  endtask

  task automatic idle(input logic [31:0] fpc);
    do_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, fpc);
  endtask

  initial begin
    logic [31:0] pc, tgt, pred, fpc;
    bit br, jal, tk;
    model_reset();
    bus.E_valid_i = 1'b0; bus.E_PC_i = '0; bus.E_op_branch_i = 1'b0; bus.E_op_jal_i = 1'b0;
    bus.E_taken_i = 1'b0; bus.E_target_i = '0; bus.E_pred_nPC_i = '0;
    bus.F_PC_i = 32'h0000_0010;
    #3;
    check("rst_predict", {31'b0, bus.F_train_predict_o}, 32'd0);
    check_reset_outputs("rst");
    #9 rst = 1'b1;
    @(posedge clk_i); #1;

    // Correct prediction of a plain instruction.
    do_cycle(1, 32'h100, 0, 0, 0, 32'h0, 32'h104, 32'h10);
    // Taken mispredict, then wrong-path branch during the flush.
    do_cycle(1, 32'h200, 1, 0, 1, 32'h180, 32'h204, 32'h200);
    do_cycle(1, 32'h208, 1, 0, 1, 32'h400, 32'h20C, 32'h208);
    do_cycle(1, 32'h208, 1, 0, 1, 32'h400, 32'h20C, 32'h208);
    idle(32'h208);
    idle(32'h200);
    // Not-taken mispredict: no refill, PHT[0] decrements.
    do_cycle(1, 32'h300, 1, 0, 0, 32'h340, 32'h340, 32'h300);
    idle(32'h300);
    idle(32'h300);
    // Saturation and bypass at index 0.
    for (int i = 0; i < 4; i++) do_cycle(1, 32'h20, 1, 0, 1, 32'h40, 32'h40, 32'h20);
    do_cycle(1, 32'h20, 1, 0, 0, 32'h40, 32'h24, 32'h20);
    idle(32'h20);
    // jal mispredict; branch+jal together acts as jal (no training).
    do_cycle(1, 32'h44, 0, 1, 0, 32'h80, 32'h48, 32'h44);
    idle(32'h44); idle(32'h44);
    do_cycle(1, 32'h48, 1, 1, 0, 32'h90, 32'h4C, 32'h48);
    idle(32'h48); idle(32'h48);
    // PC wraps modulo 2^32.
    do_cycle(1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    do_cycle(1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 32'h4, 32'h0);
    idle(32'h0); idle(32'h0);

    // Reset asserted mid-flush aborts it at once.
    do_cycle(1, 32'h500, 1, 0, 1, 32'h600, 32'h504, 32'h500);
    bus.E_valid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midflush_rst");
    check("midflush_rst_predict", {31'b0, bus.F_train_predict_o}, 32'd0);
    model_reset();
    @(negedge clk_i);
    rst = 1'b1;
    @(posedge clk_i); #1;
    idle(32'h500);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      pc  = 32'h1000 + ($urandom_range(0, 15) << 2);
      tgt = 32'h2000 + ($urandom_range(0, 63) << 2);
      fpc = 32'h1000 + ($urandom_range(0, 15) << 2);
      br  = ($urandom_range(0, 3) != 0);
      jal = ($urandom_range(0, 7) == 0);
      tk  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) pred = (jal || (br && tk)) ? tgt : pc + 32'd4;
      else pred = ($urandom_range(0, 1) == 1) ? tgt : pc + 32'd4;
      do_cycle($urandom_range(0, 4) != 0, pc, br, jal, tk, tgt, pred, fpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
